bnn_mac_accum: RTL and testbench

Multi-lane binary multiply-accumulate unit for the neural network accelerator datapath. It is the parametrised successor of the single-bit ±1 ALU. Each accepted beat takes LANES binary activation/weight pairs. Every enabled lane contributes +1 (match) or −1 (mismatch) to a signed accumulator preloaded with a bias. After the last beat it presents the signed pre-activation sum and its binary activation through a valid/ready output handshake. It sits between the activation/weight fetch buffers and the layer output writer.

---
 rtl/bnn_mac_accum.sv | 110 +++++++++++
 tb/tb_bnn_mac_accum.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_mac_accum.sv
// Multi-lane binary (+1/-1) multiply-accumulate with bias preload and a valid/ready result.
// Optional saturation on overflow is enabled by defining BNN_ACC_SAT_EN; otherwise the accumulator wraps.
module bnn_mac_accum #(
  parameter int ACC_WIDTH = 12,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [LANES-1:0]     x_bits,
  input  logic [LANES-1:0]     w_bits,
  input  logic [LANES-1:0]     lane_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 act_out,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic                 sat_flag
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_ONE = ACC_WIDTH'(1);

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_next, beat_sum;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 start_fire, beat_fire;

  assign start_fire = (state_q == IDLE) && start;
  assign beat_fire  = (state_q == ACCUM) && in_valid;

  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        beat_sum = (x_bits[i] ^ w_bits[i]) ? beat_sum - ACC_ONE : beat_sum + ACC_ONE;
      end
    end
  end

`ifdef BNN_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_wide;
  logic               ovf;
  logic               sat_q;

  // Guard bit disagreeing with the result MSB means the signed sum left the range.
  always_comb begin
    sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {beat_sum[ACC_WIDTH-1], beat_sum};
    ovf      = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    if (!ovf)                   acc_next = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH]) acc_next = ACC_MIN;
    else                        acc_next = ACC_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                sat_q <= 1'b0;
    else if (start_fire)       sat_q <= 1'b0;
    else if (beat_fire && ovf) sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`else
  always_comb acc_next = acc_q + beat_sum;

  assign sat_flag = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (in_valid && in_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_fire) begin
        acc_q <= bias;
        cnt_q <= '0;
      end else if (beat_fire) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == DONE);
  assign acc_out    = acc_q;
  assign act_out    = ~acc_q[ACC_WIDTH-1];
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_bnn_mac_accum.sv
// Self-checking bench for bnn_mac_accum: vector table, result scoreboard, and handshake/reset sequences.
module tb_bnn_mac_accum;

  localparam int AW = 12;
  localparam int LN = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_last, out_ready;
  logic [AW-1:0] bias;
  logic [LN-1:0] x_bits, w_bits, lane_en;
  logic          in_ready, out_valid, act_out, sat_flag;
  logic [AW-1:0] acc_out;
  logic [CW-1:0] beat_count;

  bnn_mac_accum #(.ACC_WIDTH(AW), .LANES(LN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .x_bits(x_bits), .w_bits(w_bits), .lane_en(lane_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .act_out(act_out), .beat_count(beat_count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             bias;
    int             n;
    logic [2:0][3:0] x;
    logic [2:0][3:0] w;
    logic [2:0][3:0] en;
    int             exp_acc;
    bit             exp_sat;
  } vec_t;

  typedef struct {
    int acc;
    int act;
    int cnt;
    int sat;
  } res_t;

  vec_t vecs[7];
  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_acc;

  task automatic chk(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] x, input logic [3:0] w, input logic [3:0] en, input logic last);
    in_valid = 1'b1;
    x_bits   = x;
    w_bits   = w;
    lane_en  = en;
    in_last  = last;
  endtask

  // Runs one product to DONE and checks the scoreboard entry; optionally completes the handshake.
  task automatic run_vec(input vec_t v, input bit handshake);
    res_t e, g;
    int   k;
    start = 1'b1;
    bias  = AW'(v.bias);
    tick();
    start = 1'b0;
    chk("in_ready_after_start", int'(in_ready), 1);
    for (int b = 0; b < v.n; b++) begin
      set_beat(v.x[b], v.w[b], v.en[b], (b == v.n - 1));
      if (b == v.n - 1) begin
        e.acc = v.exp_acc;
        e.act = (v.exp_acc >= 0) ? 1 : 0;
        e.cnt = v.n;
        e.sat = int'(v.exp_sat);
        sb.push_back(e);
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_latency", int'(out_valid), 1);
    k = 0;
    while (!out_valid && k < 8) begin
      tick();
      k++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
    chk("in_ready_in_done", int'(in_ready), 0);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 expected 1");
    end else begin
      g = sb.pop_front();
      chk("acc_out", int'($signed(acc_out)), g.acc);
      chk("act_out", int'(act_out), g.act);
      chk("beat_count", int'(beat_count), g.cnt);
      chk("sat_flag", int'(sat_flag), g.sat);
      last_acc = g.acc;
    end
    if (handshake) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_after_hs", int'(out_valid), 0);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_acc_out", int'(acc_out), 0);
    chk("rst_act_out", int'(act_out), 1);
    chk("rst_beat_count", int'(beat_count), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
  endtask

  initial begin
    vecs[0] = '{5, 3, {4'b1100, 4'b1111, 4'b1010}, {4'b1000, 4'b0000, 4'b1010},
                {4'b0111, 4'b1111, 4'b1111}, 6, 1'b0};
    vecs[1] = '{-3, 1, {4'b0, 4'b0, 4'b1111}, {4'b0, 4'b0, 4'b0000},
                {4'b0, 4'b0, 4'b1111}, -7, 1'b0};
    vecs[2] = '{0, 1, {4'b0, 4'b0, 4'b1010}, {4'b0, 4'b0, 4'b0101},
                {4'b0, 4'b0, 4'b0000}, 0, 1'b0};
    vecs[3] = '{-1, 1, {4'b0, 4'b0, 4'b0001}, {4'b0, 4'b0, 4'b0001},
                {4'b0, 4'b0, 4'b0001}, 0, 1'b0};
`ifdef BNN_ACC_SAT_EN
    vecs[4] = '{2045, 1, {4'b0, 4'b0, 4'b0000}, {4'b0, 4'b0, 4'b0000},
                {4'b0, 4'b0, 4'b1111}, 2047, 1'b1};
    vecs[5] = '{-2047, 1, {4'b0, 4'b0, 4'b1111}, {4'b0, 4'b0, 4'b0000},
                {4'b0, 4'b0, 4'b1111}, -2048, 1'b1};
    vecs[6] = '{2047, 2, {4'b0, 4'b1111, 4'b0000}, {4'b0, 4'b0000, 4'b0000},
                {4'b0, 4'b1111, 4'b1111}, 2043, 1'b1};
`else
    vecs[4] = '{2045, 1, {4'b0, 4'b0, 4'b0000}, {4'b0, 4'b0, 4'b0000},
                {4'b0, 4'b0, 4'b1111}, -2047, 1'b0};
    vecs[5] = '{-2047, 1, {4'b0, 4'b0, 4'b1111}, {4'b0, 4'b0, 4'b0000},
                {4'b0, 4'b0, 4'b1111}, 2045, 1'b0};
    vecs[6] = '{2047, 2, {4'b0, 4'b1111, 4'b0000}, {4'b0, 4'b0000, 4'b0000},
                {4'b0, 4'b1111, 4'b1111}, 2047, 1'b0};
`endif

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    bias = '0; x_bits = '0; w_bits = '0; lane_en = '0;
    tick();
    tick();
    check_reset_vals();
    rst_n = 1'b1;

    // A beat offered while idle must be dropped.
    set_beat(4'b0000, 4'b0000, 4'b1111, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("idle_in_valid_ignored_cnt", int'(beat_count), 0);
    chk("idle_in_valid_ignored_ov", int'(out_valid), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);

    // Backpressure: stay in DONE with stray start/in_valid pulses.
    run_vec(vecs[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      start    = c[0];
      in_valid = ~c[0];
      bias     = AW'(100);
      set_beat(4'b0000, 4'b0000, 4'b1111, 1'b1);
      in_valid = ~c[0];
      tick();
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_acc_out", int'($signed(acc_out)), last_acc);
      chk("bp_beat_count", int'(beat_count), 3);
    end
    start = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("hs_out_valid", int'(out_valid), 0);
    chk("hs_start_ignored", int'(in_ready), 0);
    chk("hs_acc_held", int'($signed(acc_out)), 6);

    // Reset in the middle of an accumulation.
    start = 1'b1;
    bias  = AW'(9);
    tick();
    start = 1'b0;
    set_beat(4'b0000, 4'b0000, 4'b1111, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_beat_count", int'(beat_count), 2);
    chk("mid_acc", int'($signed(acc_out)), 17);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    run_vec('{1, 1, {4'b0, 4'b0, 4'b0000}, {4'b0, 4'b0, 4'b0000},
              {4'b0, 4'b0, 4'b0011}, 3, 1'b0}, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
